// File: rtl/approx_add_pipe.sv
// Pipelined unsigned approximate adder: low K bits approximated in stage 0, carry chain
// split into SEG_W-bit registered segments, with a saturating count of inexact results.
module approx_add_pipe #(
  parameter int WIDTH      = 12,
  parameter int SEG_W      = 4,
  parameter int MAX_APPROX = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_a,
  input  logic [WIDTH-1:0]                in_b,
  input  logic [1:0]                      in_mode,
  input  logic [$clog2(MAX_APPROX+1)-1:0] in_k,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH:0]                  out_sum,
  output logic                            out_err,
  input  logic                            err_clr,
  output logic [ERR_CNT_W-1:0]            err_cnt
);

  localparam int STAGES = (WIDTH + SEG_W - 1) / SEG_W;
  localparam int KW     = $clog2(MAX_APPROX + 1);
  localparam int SEG0   = (SEG_W < WIDTH) ? SEG_W : WIDTH;
  localparam logic [KW-1:0]  K_MAX     = KW'(MAX_APPROX);
  localparam logic [WIDTH:0] ONE       = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] SEG0_MASK = (ONE << SEG0) - ONE;

  // Handshake: a beat moves on in_valid && in_ready, a result leaves on out_valid && out_ready.
  // One global enable en = !out_valid || out_ready advances every stage at once (no bubble
  // squeezing); in_ready is en, so it depends combinationally on out_ready.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Per-stage registers; index STAGES-1 is the output stage.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic             e_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic             v_d [STAGES];
  logic             c_d [STAGES];
  logic             e_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  logic [KW-1:0] k_eff;
  logic [WIDTH:0] kmask, a0, b0, hi, lows, approx, seg0;
  logic [WIDTH:0] wm, t, placed;
  int             seg_lo, seg_len;

  // Stage 0: approximate bits [K-1:0], exact add of bits K..SEG0-1 with zero carry-in.
  always_comb begin
    k_eff = (in_k > K_MAX) ? K_MAX : in_k;
    if (in_mode == 2'd0) k_eff = '0;
    kmask = (ONE << k_eff) - ONE;
    a0    = {1'b0, in_a} & SEG0_MASK;
    b0    = {1'b0, in_b} & SEG0_MASK;
    hi    = (a0 & ~kmask) + (b0 & ~kmask);
    lows  = (a0 & kmask) + (b0 & kmask);
    case (in_mode)
      2'd1:    approx = a0 & kmask;
      2'd2:    approx = (a0 | b0) & kmask;
      default: approx = '0;
    endcase
    seg0 = (hi & SEG0_MASK) | approx;
  end

  always_comb begin
    wm      = '0;
    t       = '0;
    placed  = '0;
    seg_lo  = 0;
    seg_len = 0;
    for (int s = 0; s < STAGES; s++) begin
      v_d[s] = 1'b0;
      c_d[s] = 1'b0;
      e_d[s] = 1'b0;
      a_d[s] = '0;
      b_d[s] = '0;
      s_d[s] = '0;
    end

    v_d[0] = in_valid;
    a_d[0] = in_a;
    b_d[0] = in_b;
    s_d[0] = seg0[WIDTH-1:0];
    c_d[0] = hi[SEG0];
    // Inexact when the approximated bits differ or the exact low add would carry into bit K.
    e_d[0] = (approx != (lows & kmask)) || lows[k_eff];

    for (int s = 1; s < STAGES; s++) begin
      seg_lo  = s * SEG_W;
      seg_len = (WIDTH - seg_lo < SEG_W) ? (WIDTH - seg_lo) : SEG_W;
      wm      = (ONE << seg_len) - ONE;
      t       = (({1'b0, a_q[s-1]} >> seg_lo) & wm)
              + (({1'b0, b_q[s-1]} >> seg_lo) & wm)
              + {{WIDTH{1'b0}}, c_q[s-1]};
      placed  = (t & wm) << seg_lo;
      v_d[s]  = v_q[s-1];
      a_d[s]  = a_q[s-1];
      b_d[s]  = b_q[s-1];
      e_d[s]  = e_q[s-1];
      s_d[s]  = s_q[s-1] | placed[WIDTH-1:0];
      c_d[s]  = t[seg_len];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= 1'b0;
        c_q[s] <= 1'b0;
        e_q[s] <= 1'b0;
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= v_d[s];
        c_q[s] <= c_d[s];
        e_q[s] <= e_d[s];
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
        s_q[s] <= s_d[s];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = {c_q[STAGES-1], s_q[STAGES-1]};
  assign out_err   = e_q[STAGES-1];

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
